// File: rtl/alu_control_seq.sv
// ALU control stage: registered op/func decode plus MULT/DIV multi-cycle sequencing.
// Optional macro ALUCTRL_EXT_OPS_EN adds XOR, NOR and SLTU decodes.
module alu_control_seq #(
    parameter int FUNC_W  = 6,
    parameter int OP_W    = 2,
    parameter int CTRL_W  = 4,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [OP_W-1:0]   op,
    input  logic [FUNC_W-1:0] func,
    input  logic              stall_in,
    input  logic              flush,
    output logic              in_ready,
    output logic              out_valid,
    output logic [CTRL_W-1:0] control,
    output logic              illegal,
    output logic              busy,
    output logic              hilo_we
);

    // state | meaning
    // IDLE  | ready to accept a new op/func
    // MCYC  | MULT/DIV executing, counter counts down to the HI/LO write
    typedef enum logic {IDLE, MCYC} state_t;

    localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

    localparam logic [CNT_W-1:0]  MUL_CNT  = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0]  DIV_CNT  = CNT_W'(DIV_LAT - 1);
    localparam logic [FUNC_W-1:0] FUNC_LOW = FUNC_W'(6'h3f);
    localparam logic [OP_W-1:0]   OP_LOW   = OP_W'(2'b11);

    state_t           state;
    logic [CNT_W-1:0] count;

    logic [5:0]        func_lo;
    logic [1:0]        op_lo;
    logic              upper_nz;
    logic [3:0]        code;
    logic              dec_ill;
    logic              dec_mul;
    logic              dec_div;
    logic [CTRL_W-1:0] dec_ctrl;
    logic              accept;

    assign func_lo  = func[5:0];
    assign op_lo    = op[1:0];
    assign upper_nz = (|(func & ~FUNC_LOW)) | (|(op & ~OP_LOW));

    always_comb begin
        code    = 4'b1111;
        dec_ill = 1'b0;
        dec_mul = 1'b0;
        dec_div = 1'b0;
        case (op_lo)
            2'b00: code = 4'b0010;
            2'b01: code = 4'b0110;
            2'b10: begin
                case (func_lo)
                    6'b100000: code = 4'b0010;
                    6'b100010: code = 4'b0110;
                    6'b100100: code = 4'b0000;
                    6'b100101: code = 4'b0001;
                    6'b101010: code = 4'b0111;
                    6'b011000: begin code = 4'b1000; dec_mul = 1'b1; end
                    6'b011010: begin code = 4'b1001; dec_div = 1'b1; end
`ifdef ALUCTRL_EXT_OPS_EN
                    6'b100110: code = 4'b1101;
                    6'b100111: code = 4'b1100;
                    6'b101011: code = 4'b1010;
`endif
                    default:   dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
        if (upper_nz) begin
            dec_ill = 1'b1;
            dec_mul = 1'b0;
            dec_div = 1'b0;
        end
        dec_ctrl = dec_ill ? '1 : CTRL_W'(code);
    end

    assign in_ready = (state == IDLE) && !stall_in && rst_n;
    assign accept   = in_valid && in_ready && !flush;

    // The HI/LO write must vanish in the same cycle as a stall, flush or reset,
    // so it is gated combinationally from the registered terminal count.
    assign hilo_we  = (state == MCYC) && (count == '0) && !stall_in && !flush && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            out_valid <= 1'b0;
            control   <= '0;
            illegal   <= 1'b0;
            busy      <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            count     <= '0;
            out_valid <= 1'b0;
            illegal   <= 1'b0;
            busy      <= 1'b0;
        end else if (!stall_in) begin
            out_valid <= accept;
            illegal   <= accept && dec_ill;
            if (accept) begin
                control <= dec_ctrl;
            end
            case (state)
                IDLE: begin
                    if (accept && (dec_mul || dec_div)) begin
                        state <= MCYC;
                        busy  <= 1'b1;
                        count <= dec_mul ? MUL_CNT : DIV_CNT;
                    end
                end
                MCYC: begin
                    if (count == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_control_seq.sv
// Bench for alu_control_seq: directed scenarios then random traffic against a
// cycle-level reference model that tracks remaining execute cycles.
module tb_alu_control_seq;

    localparam int FUNC_W  = 6;
    localparam int OP_W    = 2;
    localparam int CTRL_W  = 4;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [OP_W-1:0]   op;
    logic [FUNC_W-1:0] func;
    logic              stall_in;
    logic              flush;
    logic              in_ready;
    logic              out_valid;
    logic [CTRL_W-1:0] control;
    logic              illegal;
    logic              busy;
    logic              hilo_we;

    alu_control_seq #(
        .FUNC_W (FUNC_W),
        .OP_W   (OP_W),
        .CTRL_W (CTRL_W),
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .op       (op),
        .func     (func),
        .stall_in (stall_in),
        .flush    (flush),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .control  (control),
        .illegal  (illegal),
        .busy     (busy),
        .hilo_we  (hilo_we)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: registered outputs plus cycles of execution still owed.
    int m_left = 0;
    int m_ctrl = 0;
    bit m_ov   = 1'b0;
    bit m_ill  = 1'b0;

    // Returns the ALU control code, or -1 when the combination is unsupported.
    function automatic int ref_code(input int o, input int f);
        if (o == 0) return 2;
        if (o == 1) return 6;
        if (o != 2) return -1;
        case (f)
            'h20: return 2;
            'h22: return 6;
            'h24: return 0;
            'h25: return 1;
            'h2a: return 7;
            'h18: return 8;
            'h1a: return 9;
`ifdef ALUCTRL_EXT_OPS_EN
            'h26: return 13;
            'h27: return 12;
            'h2b: return 10;
`endif
            default: return -1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic step(input logic iv, input logic [1:0] o, input logic [5:0] f,
                        input logic st, input logic fl, input logic rn);
        bit exp_ready;
        bit exp_hilo;
        int c;
        @(negedge clk);
        in_valid = iv;
        op       = o;
        func     = f;
        stall_in = st;
        flush    = fl;
        rst_n    = rn;
        #1;
        exp_ready = (m_left == 0) && !st && rn;
        exp_hilo  = (m_left == 1) && !st && !fl && rn;
        chk("in_ready",  32'(in_ready),  32'(exp_ready));
        chk("hilo_we",   32'(hilo_we),   32'(exp_hilo));
        chk("busy",      32'(busy),      32'(m_left > 0));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("illegal",   32'(illegal),   32'(m_ill));
        chk("control",   32'(control),   32'(m_ctrl));
        if (!rn) begin
            m_left = 0; m_ov = 0; m_ill = 0; m_ctrl = 0;
        end else if (fl) begin
            m_left = 0; m_ov = 0; m_ill = 0;
        end else if (!st) begin
            if (m_left > 0) m_left--;
            if (iv && exp_ready) begin
                c    = ref_code(int'(o), int'(f));
                m_ov = 1;
                if (c < 0) begin
                    m_ill  = 1;
                    m_ctrl = (1 << CTRL_W) - 1;
                end else begin
                    m_ill  = 0;
                    m_ctrl = c;
                    if (c == 8) m_left = MUL_LAT;
                    if (c == 9) m_left = DIV_LAT;
                end
            end else begin
                m_ov  = 0;
                m_ill = 0;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 6'h00, 1'b0, 1'b0, 1'b1);
    endtask

    logic [5:0] funcs [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a,
                               6'h18, 6'h1a, 6'h26, 6'h27, 6'h2b};

    initial begin
        logic [5:0] rf;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        op       = '0;
        func     = '0;
        stall_in = 1'b0;
        flush    = 1'b0;
        repeat (2) @(posedge clk);
        step(1'b0, 2'b00, 6'h00, 1'b0, 1'b0, 1'b0);

        // AND decode, one-cycle valid pulse
        step(1'b1, 2'b10, 6'h24, 1'b0, 1'b0, 1'b1);
        idle(2);

        // MULT with a second request held until the stage frees up
        step(1'b1, 2'b10, 6'h18, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 2'b00, 6'h00, 1'b0, 1'b0, 1'b1);
        idle(2);

        // DIV flushed early; a request presented with flush is dropped
        step(1'b1, 2'b10, 6'h1a, 1'b0, 1'b0, 1'b1);
        idle(2);
        step(1'b0, 2'b00, 6'h00, 1'b0, 1'b1, 1'b1);
        idle(2);
        step(1'b1, 2'b01, 6'h00, 1'b0, 1'b1, 1'b1);
        idle(1);

        // DIV flushed exactly at terminal count
        step(1'b1, 2'b10, 6'h1a, 1'b0, 1'b0, 1'b1);
        idle(7);
        step(1'b0, 2'b00, 6'h00, 1'b0, 1'b1, 1'b1);
        idle(2);

        // illegal and extended-op decodes
        step(1'b1, 2'b10, 6'h3f, 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'b10, 6'h27, 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'b11, 6'h20, 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'b10, 6'h2a, 1'b0, 1'b0, 1'b1);
        idle(2);

        // MULT with a 3-cycle stall in the middle
        step(1'b1, 2'b10, 6'h18, 1'b0, 1'b0, 1'b1);
        idle(1);
        for (int i = 0; i < 3; i++) step(1'b1, 2'b10, 6'h20, 1'b1, 1'b0, 1'b1);
        idle(5);

        // reset asserted mid-MULT
        step(1'b1, 2'b10, 6'h18, 1'b0, 1'b0, 1'b1);
        idle(1);
        step(1'b0, 2'b00, 6'h00, 1'b0, 1'b0, 1'b0);
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            rf = ($urandom_range(0, 3) == 0) ? 6'($urandom) : funcs[$urandom_range(0, 9)];
            step(1'($urandom_range(0, 2) != 0), 2'($urandom), rf,
                 1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 63) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
- Registered, parametrised ALU-control stage for the pipelined datapath.
- Decodes the ALU op class and the R-type function field into an ALU control code, one cycle after accept.
- Also sequences multi-cycle MULT/DIV operations, driving busy/backpressure and a HI/LO write strobe.
- Sits at the ID/EX boundary: driven by the main decoder, feeds the EX-stage ALU and the HI/LO unit.

Parameters:
- FUNC_W, 6, function-field width; must be >= 6.
- OP_W, 2, ALU op-class width; must be >= 2.
- CTRL_W, 4, control-code width; must be >= 4; codes are zero-extended.
- MUL_LAT, 4, MULT execute cycles; must be >= 1.
- DIV_LAT, 8, DIV execute cycles; must be >= 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  op/func valid this cycle
- op  in  OP_W  ALU op class
- func  in  FUNC_W  R-type function field
- stall_in  in  1  downstream hold
- flush  in  1  squash the in-flight operation
- in_ready  out  1  stage can accept
- out_valid  out  1  control is valid
- control  out  CTRL_W  ALU control code
- illegal  out  1  unsupported op/func
- busy  out  1  multi-cycle op in progress
- hilo_we  out  1  HI/LO write strobe, one cycle

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n).
- Reset state: state=IDLE, counter=0. Outputs out_valid, control, illegal, busy and hilo_we are all 0.
- in_ready = (state==IDLE) && !stall_in && rst_n. accept = in_valid && in_ready.
- Decode (registered, 1-cycle latency; on accept in cycle N, results appear in cycle N+1):
  - op=00 -> 0010 (add); op=01 -> 0110 (sub); op=11 -> illegal.
  - op=10, func decode: 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111, 011000 (MULT)->1000, 011010 (DIV)->1001.
  - Any other func -> illegal.
  - func bits above bit 5 nonzero -> illegal. Only op[1:0] is decoded; upper op bits nonzero -> illegal.
  - Illegal result: control=all ones, illegal=1, out_valid=1, no FSM transition.
- No accept and no stall: out_valid=0 and illegal=0 next cycle. control holds its last value.
- stall_in=1: all registers hold, including FSM state and counter. No accept. hilo_we is forced 0 while stalled.
- FSM states: IDLE, MCYC.
- IDLE -> MCYC on accept of MULT/DIV.
  - Counter loads LAT-1; busy=1, out_valid=1 for one cycle (N+1).
- MCYC: counter decrements each unstalled cycle.
  - At counter==0: hilo_we=1 that cycle, busy=0 from the next cycle, state -> IDLE.
  - busy is high in cycles N+1..N+LAT. hilo_we pulses in cycle N+LAT. in_ready returns in cycle N+LAT+1.
  - LAT=1: busy and hilo_we are both high in cycle N+1 only.
- flush=1 has priority over accept, stall_in and counter expiry:
  - next cycle: out_valid=0, illegal=0, busy=0, state=IDLE.
  - hilo_we suppressed in the flush cycle, even if counter==0.
  - An in_valid presented with flush is dropped.
- rst_n low mid-MCYC: immediate return to reset state at the next edge, no hilo_we.

Optional Feature:
- Macro: ALUCTRL_EXT_OPS_EN.
- Defined: op=10 additionally decodes func 100110 (XOR) -> 1101, 100111 (NOR) -> 1100, 101011 (SLTU) -> 1010.
- Undefined: those funcs decode as illegal (control=all ones, illegal=1).

Test Plan:
- Reset, then accept op=10/func=100100 in cycle N -> cycle N+1: out_valid=1, control=0000, illegal=0. Cycle N+2: out_valid=0.
- Accept op=10/func=011000, MUL_LAT=4, cycle N:
  - busy=1 in N+1..N+4, control=1000, out_valid=1 in N+1 only.
  - hilo_we=1 in N+4 only; in_ready=0 through N+4, 1 at N+5.
  - A second in_valid held from N+1 is accepted at N+5.
- DIV (DIV_LAT=8) accepted cycle N, flush in N+3 -> busy=0 from N+4, hilo_we never asserted, in_ready=1 at N+4.
- DIV accepted, flush coincident with counter==0 -> no hilo_we; state IDLE next cycle.
- op=10/func=111111 -> control=1111, illegal=1, out_valid=1, busy=0.
  - With macro undefined, func=100111 gives the same illegal response.
  - With macro defined, func=100111 -> control=1100, illegal=0.
- stall_in high for 3 cycles mid-MULT -> counter, busy and outputs frozen; hilo_we delayed exactly 3 cycles. rst_n low mid-MULT -> all outputs 0 next edge.
